// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived totals and the phase encoding
// used by both the horizontal and vertical sequencers.
`timescale 1ns/1ps
package vga_timing_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   localparam int H_TOTAL_D =
      H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int V_TOTAL_D =
      V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

   typedef enum logic [1:0] {
      PH_ACT,
      PH_FRONT,
      PH_SYN,
      PH_BACK
   } phase_t;

   function automatic logic [15:0] last_of(input int len);
      return 16'(len - 1);
   endfunction

endpackage

// File: rtl/vga_phase_counter.sv
// Four-phase sequencer (active/front/sync/back) with an in-phase counter
// and an absolute position; exposes next-state phase and a wrap pulse.
`timescale 1ns/1ps
module vga_phase_counter
   import vga_timing_pkg::*;
#(
   parameter int ACT = H_ACTIVE_D,
   parameter int FP  = H_FP_D,
   parameter int SYN = H_SYNC_D,
   parameter int BP  = H_BP_D
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        adv,
   output logic [15:0] pos,
   output phase_t      phase_nxt,
   output logic        wrap
);

   localparam logic [15:0] TOTAL_M1 = last_of(ACT + FP + SYN + BP);

   phase_t      phase;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic [15:0] pos_nxt;
   logic [15:0] last;

   always_comb begin
      last = last_of(ACT);
      unique case (phase)
         PH_ACT:   last = last_of(ACT);
         PH_FRONT: last = last_of(FP);
         PH_SYN:   last = last_of(SYN);
         PH_BACK:  last = last_of(BP);
      endcase
   end

   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      pos_nxt   = pos;
      wrap      = 1'b0;
      if (adv) begin
         pos_nxt = (pos == TOTAL_M1) ? 16'd0 : pos + 16'd1;
         if (cnt == last) begin
            cnt_nxt = 16'd0;
            unique case (phase)
               PH_ACT:   phase_nxt = PH_FRONT;
               PH_FRONT: phase_nxt = PH_SYN;
               PH_SYN:   phase_nxt = PH_BACK;
               PH_BACK: begin
                  phase_nxt = PH_ACT;
                  wrap      = 1'b1;
               end
            endcase
         end else begin
            cnt_nxt = cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         phase <= PH_ACT;
         cnt   <= 16'd0;
         pos   <= 16'd0;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
         pos   <= pos_nxt;
      end
   end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: horizontal sequencer drives the vertical one on wrap;
// sync/blank/pulse outputs are registered from next-state phases.
`timescale 1ns/1ps
module vga_timing_controller
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        run,
   output logic [15:0] h_count,
   output logic [15:0] v_count,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start
);

   phase_t h_ph_nxt;
   phase_t v_ph_nxt;
   logic   h_wrap;
   logic   v_wrap;

   vga_phase_counter #(
      .ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP)
   ) u_h (
      .clk_25MHz(clk_25MHz),
      .rst_n    (rst_n),
      .adv      (run),
      .pos      (h_count),
      .phase_nxt(h_ph_nxt),
      .wrap     (h_wrap)
   );

   // vertical steps only on the horizontal wrap, so 799/524 -> 0/0 is one edge
   vga_phase_counter #(
      .ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP)
   ) u_v (
      .clk_25MHz(clk_25MHz),
      .rst_n    (rst_n),
      .adv      (h_wrap),
      .pos      (v_count),
      .phase_nxt(v_ph_nxt),
      .wrap     (v_wrap)
   );

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (h_ph_nxt == PH_SYN) ? SYNC_POL : ~SYNC_POL;
         vsync       <= (v_ph_nxt == PH_SYN) ? SYNC_POL : ~SYNC_POL;
         video_on    <= (h_ph_nxt == PH_ACT) && (v_ph_nxt == PH_ACT);
         line_start  <= h_wrap;
         frame_start <= v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench: default 640x480 instance plus a tiny active-high-sync instance,
// both checked every cycle against a position-based reference model.
`timescale 1ns/1ps
module tb_vga_timing_controller;

   logic clk_25MHz = 1'b0;
   logic rst_n;
   logic run;

   always #20 clk_25MHz = ~clk_25MHz;

   logic [15:0] hc [2];
   logic [15:0] vc [2];
   logic        hs [2];
   logic        vs [2];
   logic        vo [2];
   logic        ls [2];
   logic        fs [2];

   int ha  [2] = '{640, 8};
   int hf  [2] = '{16, 2};
   int hsw [2] = '{96, 3};
   int hb  [2] = '{48, 2};
   int va  [2] = '{480, 4};
   int vf  [2] = '{10, 1};
   int vsw [2] = '{2, 2};
   int vb  [2] = '{33, 1};
   bit pol [2] = '{1'b0, 1'b1};

   vga_timing_controller dut (
      .clk_25MHz  (clk_25MHz),
      .rst_n      (rst_n),
      .run        (run),
      .h_count    (hc[0]),
      .v_count    (vc[0]),
      .hsync      (hs[0]),
      .vsync      (vs[0]),
      .video_on   (vo[0]),
      .line_start (ls[0]),
      .frame_start(fs[0])
   );

   vga_timing_controller #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1'b1)
   ) dut_s (
      .clk_25MHz  (clk_25MHz),
      .rst_n      (rst_n),
      .run        (run),
      .h_count    (hc[1]),
      .v_count    (vc[1]),
      .hsync      (hs[1]),
      .vsync      (vs[1]),
      .video_on   (vo[1]),
      .line_start (ls[1]),
      .frame_start(fs[1])
   );

   int mh  [2];
   int mv  [2];
   bit mls [2];
   bit mfs [2];
   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic bit in_rng(input int x, input int lo, input int n);
      return (x >= lo) && (x < lo + n);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mh[i] = 0; mv[i] = 0; mls[i] = 0; mfs[i] = 0;
      end
   endtask

   task automatic model_step(input bit r);
      for (int i = 0; i < 2; i++) begin
         mls[i] = 0;
         mfs[i] = 0;
         if (r) begin
            mh[i]++;
            if (mh[i] == ha[i] + hf[i] + hsw[i] + hb[i]) begin
               mh[i] = 0;
               mv[i]++;
               if (mv[i] == va[i] + vf[i] + vsw[i] + vb[i]) mv[i] = 0;
            end
            mls[i] = (mh[i] == 0);
            mfs[i] = (mh[i] == 0) && (mv[i] == 0);
         end
      end
   endtask

   task automatic check_all();
      bit eh, ev;
      for (int i = 0; i < 2; i++) begin
         eh = in_rng(mh[i], ha[i] + hf[i], hsw[i]) ? pol[i] : !pol[i];
         ev = in_rng(mv[i], va[i] + vf[i], vsw[i]) ? pol[i] : !pol[i];
         chk($sformatf("d%0d h_count", i), 32'(hc[i]), 32'(mh[i]));
         chk($sformatf("d%0d v_count", i), 32'(vc[i]), 32'(mv[i]));
         chk($sformatf("d%0d hsync", i), 32'(hs[i]), 32'(eh));
         chk($sformatf("d%0d vsync", i), 32'(vs[i]), 32'(ev));
         chk($sformatf("d%0d video_on", i), 32'(vo[i]),
             32'((mh[i] < ha[i]) && (mv[i] < va[i])));
         chk($sformatf("d%0d line_start", i), 32'(ls[i]), 32'(mls[i]));
         chk($sformatf("d%0d frame_start", i), 32'(fs[i]), 32'(mfs[i]));
      end
   endtask

   task automatic step(input bit r);
      run = r;
      @(posedge clk_25MHz);
      model_step(r);
      @(negedge clk_25MHz);
      check_all();
   endtask

   task automatic run_to(input int i, input int h, input int v);
      int k = 0;
      while (!(mh[i] == h && mv[i] == v) && k < 20000) begin
         step(1'b1);
         k++;
      end
      chk($sformatf("d%0d reach h", i), 32'(hc[i]), 32'(h));
      chk($sformatf("d%0d reach v", i), 32'(vc[i]), 32'(v));
   endtask

   initial begin
      int fcnt;
      int fcyc;
      rst_n = 1'b1;
      run   = 1'b0;
      #7 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk_25MHz);
      @(negedge clk_25MHz);
      rst_n = 1'b1;

      // first line on the default instance, first frame on the small one
      fcnt = 0;
      fcyc = 0;
      for (int c = 1; c <= 799; c++) begin
         step(1'b1);
         if (c == 1) chk("first h", 32'(hc[0]), 32'd1);
         if (fs[1] === 1'b1 && c <= 120) begin
            fcnt++;
            fcyc = c;
         end
      end
      chk("s frame pulses", 32'(fcnt), 32'd1);
      chk("s frame cycle", 32'(fcyc), 32'd120);
      chk("h at 799", 32'(hc[0]), 32'd799);
      step(1'b1);
      chk("h wrap", 32'(hc[0]), 32'd0);
      chk("ls wrap", 32'(ls[0]), 32'd1);
      chk("v after wrap", 32'(vc[0]), 32'd1);

      repeat (3000) step($urandom_range(0, 3) != 0);

      // freeze inside hsync, then resume
      run_to(0, 700, 10);
      chk("hsync active", 32'(hs[0]), 32'd0);
      repeat (50) begin
         step(1'b0);
         chk("frz h", 32'(hc[0]), 32'd700);
         chk("frz hs", 32'(hs[0]), 32'd0);
      end
      step(1'b1);
      chk("resume h", 32'(hc[0]), 32'd701);
      chk("resume ls", 32'(ls[0]), 32'd0);

      // asynchronous reset while hsync is active
      run_to(0, 700, 11);
      #5 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      chk("arst h", 32'(hc[0]), 32'd0);
      chk("arst hsync", 32'(hs[0]), 32'd1);
      @(negedge clk_25MHz);
      rst_n = 1'b1;
      step(1'b1);
      chk("post rst h", 32'(hc[0]), 32'd1);

      // blanking boundaries and coincident wrap on the small instance
      run_to(1, 7, 3);
      chk("s vo last", 32'(vo[1]), 32'd1);
      run_to(1, 8, 0);
      chk("s vo hblank", 32'(vo[1]), 32'd0);
      run_to(1, 0, 4);
      chk("s vo vblank", 32'(vo[1]), 32'd0);
      run_to(1, 14, 7);
      step(1'b1);
      chk("s wrap fs", 32'(fs[1]), 32'd1);
      chk("s wrap ls", 32'(ls[1]), 32'd1);
      chk("s wrap v", 32'(vc[1]), 32'd0);

      repeat (1000) step($urandom_range(0, 3) != 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
